// File: rtl/btb_pkg.sv
// Shared BTB definitions: geometry, 2-bit counter encodings and the per-prediction
// metadata record handed from the lookup side to the resolve/update side.
package btb_pkg;

  localparam int TAGW     = 27;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int NUM_WAYS = 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_ctr_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        way;
    logic        taken;
    logic        lru;
  } btb_meta_t;

  function automatic logic ctr_taken(input logic [1:0] state);
    return (state == WT) || (state == ST);
  endfunction

endpackage

// File: rtl/btb_meta_fifo.sv
// In-order metadata FIFO between prediction and resolve. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module btb_meta_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_flush,
  input  logic      i_push,
  input  btb_meta_t i_data,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output btb_meta_t o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  btb_meta_t     r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it was written,
  // and leaving it out keeps the array mappable onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/btb_predict.sv
// Fetch-side BTB lookup: 2-way tag compare, registered taken/target prediction with
// valid/ready handshake, and a metadata FIFO consumed by the resolve path.
module btb_predict
  import btb_pkg::*;
#(
  parameter int TAGW  = btb_pkg::TAGW,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  output logic [2:0]        rd_set,
  input  logic              rd_valid0,
  input  logic              rd_valid1,
  input  logic [TAGW-1:0]   rd_tag0,
  input  logic [TAGW-1:0]   rd_tag1,
  input  logic [31:0]       rd_target0,
  input  logic [31:0]       rd_target1,
  input  logic [1:0]        rd_state0,
  input  logic [1:0]        rd_state1,
  input  logic              rd_lru,
  output logic              pred_valid,
  input  logic              pred_ready,
  output logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic              meta_valid,
  input  logic              meta_pop,
  output logic [31:0]       meta_pc,
  output logic              meta_hit,
  output logic              meta_way,
  output logic              meta_taken,
  output logic              meta_lru
);

  logic [TAGW-1:0] w_tag;
  logic            w_hit0;
  logic            w_hit1;
  logic            w_hit;
  logic            w_way;
  logic            w_taken;
  logic [31:0]     w_pc_plus4;
  logic [31:0]     w_target;
  logic            w_accept;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  btb_meta_t       w_meta_in;
  btb_meta_t       w_meta_head;

  logic            r_pred_valid;
  logic [31:0]     r_pred_pc;
  logic            r_pred_taken;
  logic [31:0]     r_pred_target;

  assign rd_set     = fetch_pc[OFFSET_W +: INDEX_W];
  assign w_tag      = fetch_pc[31 -: TAGW];
  assign w_hit0     = rd_valid0 && (rd_tag0 == w_tag);
  assign w_hit1     = rd_valid1 && (rd_tag1 == w_tag);
  assign w_pc_plus4 = fetch_pc + 32'd4;

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    w_hit    = 1'b0;
    w_way    = 1'b0;
    w_taken  = 1'b0;
    w_target = w_pc_plus4;
    if (w_hit0) begin
      w_hit   = 1'b1;
      w_taken = ctr_taken(rd_state0);
      if (w_taken) w_target = rd_target0;
    end else if (w_hit1) begin
      w_hit   = 1'b1;
      w_way   = 1'b1;
      w_taken = ctr_taken(rd_state1);
      if (w_taken) w_target = rd_target1;
    end
  end

  assign fetch_ready = rst && !flush && !w_fifo_full && (!r_pred_valid || pred_ready);
  assign w_accept    = fetch_valid && fetch_ready;

  always_comb begin
    w_meta_in.pc    = fetch_pc;
    w_meta_in.hit   = w_hit;
    w_meta_in.way   = w_way;
    w_meta_in.taken = w_taken;
    w_meta_in.lru   = rd_lru;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_pc     <= '0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else if (flush) begin
      r_pred_valid  <= 1'b0;
    end else if (w_accept) begin
      r_pred_valid  <= 1'b1;
      r_pred_pc     <= fetch_pc;
      r_pred_taken  <= w_taken;
      r_pred_target <= w_target;
    end else if (pred_ready) begin
      r_pred_valid  <= 1'b0;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_pc     = r_pred_pc;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

  btb_meta_fifo #(
    .DEPTH (DEPTH)
  ) u_meta_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (flush),
    .i_push  (w_accept),
    .i_data  (w_meta_in),
    .i_pop   (meta_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_meta_head)
  );

  assign meta_valid = !w_fifo_empty;
  assign meta_pc    = w_meta_head.pc;
  assign meta_hit   = w_meta_head.hit;
  assign meta_way   = w_meta_head.way;
  assign meta_taken = w_meta_head.taken;
  assign meta_lru   = w_meta_head.lru;

endmodule
